// File: rtl/alu_bus_master.sv
// Initiator for the shared-bus ALU: loads R0 and R1 over the tristate bus, then issues the compute op and samples the result.
// Accept to resp_valid takes 3+TURNAROUND cycles; new requests wait until the previous response is taken.
module alu_bus_master #(
  parameter int WIDTH      = 8,
  parameter int TURNAROUND = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic [2:0]       op,
  inout  wire  [WIDTH-1:0] bus,
  output logic             busy,
  output logic [15:0]      txn_count
);

  localparam logic [2:0] ALU_NOP      = 3'd0;
  localparam logic [2:0] ALU_WRITE_R0 = 3'd1;
  localparam logic [2:0] ALU_WRITE_R1 = 3'd2;

  localparam logic [1:0] TURN_INIT = 2'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_A,
    ST_LOAD_B,
    ST_TURN,
    ST_EXEC,
    ST_DONE
  } state_t;

  state_t           r_state;
  logic [2:0]       r_op;
  logic [2:0]       r_lat_op;
  logic [WIDTH-1:0] r_lat_b;
  logic             r_bus_oe;
  logic [WIDTH-1:0] r_bus_dat;
  logic             r_resp_vld;
  logic [WIDTH-1:0] r_resp_dat;
  logic [15:0]      r_txn_cnt;
  logic [1:0]       r_turn_cnt;
  logic             w_accept;

  // In DONE the slot frees up on the same edge the response is taken, so a new request may ride along.
  assign req_ready  = (r_state == ST_IDLE) || ((r_state == ST_DONE) && resp_ready);
  assign w_accept   = req_valid && req_ready;
  assign resp_valid = r_resp_vld;
  assign resp_data  = r_resp_dat;
  assign op         = r_op;
  assign busy       = (r_state != ST_IDLE);
  assign txn_count  = r_txn_cnt;
  assign bus        = r_bus_oe ? r_bus_dat : {WIDTH{1'bz}};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_op       <= ALU_NOP;
      r_lat_op   <= ALU_NOP;
      r_lat_b    <= '0;
      r_bus_oe   <= 1'b0;
      r_bus_dat  <= '0;
      r_resp_vld <= 1'b0;
      r_resp_dat <= '0;
      r_txn_cnt  <= '0;
      r_turn_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: ;
        ST_LOAD_A: begin
          r_op      <= ALU_WRITE_R1;
          r_bus_dat <= r_lat_b;
          r_state   <= ST_LOAD_B;
        end
        ST_LOAD_B: begin
          r_bus_oe <= 1'b0;
          if (TURNAROUND > 0) begin
            r_op       <= ALU_NOP;
            r_turn_cnt <= TURN_INIT;
            r_state    <= ST_TURN;
          end else begin
            r_op    <= r_lat_op;
            r_state <= ST_EXEC;
          end
        end
        ST_TURN: begin
          if (r_turn_cnt == 2'd0) begin
            r_op    <= r_lat_op;
            r_state <= ST_EXEC;
          end else begin
            r_turn_cnt <= r_turn_cnt - 2'd1;
          end
        end
        ST_EXEC: begin
          r_resp_dat <= bus;
          r_resp_vld <= 1'b1;
          r_txn_cnt  <= r_txn_cnt + 16'd1;
          r_op       <= ALU_NOP;
          r_state    <= ST_DONE;
        end
        ST_DONE: begin
          if (resp_ready) begin
            r_resp_vld <= 1'b0;
            r_state    <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_accept) begin
        r_lat_op  <= req_op;
        r_lat_b   <= req_b;
        r_bus_dat <= req_a;
        r_bus_oe  <= 1'b1;
        r_op      <= ALU_WRITE_R0;
        r_state   <= ST_LOAD_A;
      end
    end
  end

endmodule

// File: tb/tb_alu_bus_master.sv
// Bench for alu_bus_master: two instances (TURNAROUND=0 and 1), each with a bus-attached ALU model and a timeline reference model.
module tb_alu_bus_master;

  localparam int W = 8;
  localparam logic [2:0] NOP = 3'd0, WR0 = 3'd1, WR1 = 3'd2, ADD = 3'd3, SUB = 3'd4;
  localparam logic [2:0] ANDO = 3'd5, ORO = 3'd6, XORO = 3'd7;
  localparam logic [W-1:0] ZZ = {W{1'bz}};
  localparam int NRAND = 40;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;
  bit done_l[2];

  logic           req_valid[2];
  logic           resp_ready[2];
  logic [2:0]     req_op[2];
  logic [W-1:0]   req_a[2];
  logic [W-1:0]   req_b[2];
  logic           req_ready[2];
  logic           resp_valid[2];
  logic           busy[2];
  logic [W-1:0]   resp_data[2];
  logic [2:0]     op_o[2];
  logic [15:0]    txn[2];

  function automatic logic [W-1:0] alu_f(logic [2:0] o, logic [W-1:0] a, logic [W-1:0] b);
    case (o)
      ADD:     return a + b;
      SUB:     return a - b;
      ANDO:    return a & b;
      ORO:     return a | b;
      XORO:    return a ^ b;
      default: return '0;
    endcase
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_bus(string nm, bit rel_act, logic [W-1:0] act, bit rel_exp, logic [W-1:0] exp);
    tests++;
    if (rel_act != rel_exp || (!rel_exp && act !== exp)) begin
      fails++;
      $display("FAIL %s: bus released=%0b value=0x%0h, want released=%0b value=0x%0h (t=%0t)",
               nm, rel_act, act, rel_exp, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int TA = g;
    wire [W-1:0] bus;
    logic [W-1:0] r0, r1;

    // ALU side: loads its registers from the bus and drives the result while a compute op is presented.
    assign bus = (op_o[g] >= ADD) ? alu_f(op_o[g], r0, r1) : ZZ;
    always @(posedge clock) begin
      if (op_o[g] == WR0) r0 <= bus;
      if (op_o[g] == WR1) r1 <= bus;
    end

    alu_bus_master #(.WIDTH(W), .TURNAROUND(TA)) dut (
      .clock      (clock),
      .reset      (reset),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_op     (req_op[g]),
      .req_a      (req_a[g]),
      .req_b      (req_b[g]),
      .resp_valid (resp_valid[g]),
      .resp_ready (resp_ready[g]),
      .resp_data  (resp_data[g]),
      .op         (op_o[g]),
      .bus        (bus),
      .busy       (busy[g]),
      .txn_count  (txn[g])
    );

    // Reference: m_t counts edges since accept; the result lands 3+TA edges after it.
    bit           m_act = 0, m_pend = 0, m_acc;
    int           m_t = 0;
    logic [2:0]   m_op = NOP;
    logic [W-1:0] m_a = '0, m_b = '0, m_res = '0;
    logic [15:0]  m_cnt = '0;

    always @(posedge clock or posedge reset) begin
      if (reset) begin
        m_act = 0; m_pend = 0; m_t = 0; m_res = '0; m_cnt = '0;
      end else begin
        m_acc = req_valid[g] && !m_act && (!m_pend || resp_ready[g]);
        if (m_pend && resp_ready[g]) m_pend = 0;
        if (m_act) begin
          m_t++;
          if (m_t == 3 + TA) begin
            m_act = 0; m_pend = 1; m_res = alu_f(m_op, m_a, m_b); m_cnt++;
          end
        end
        if (m_acc) begin
          m_act = 1; m_t = 0; m_op = req_op[g]; m_a = req_a[g]; m_b = req_b[g];
        end
      end
    end

    always @(negedge clock) begin
      logic [2:0]   e_op;
      logic [W-1:0] e_bus;
      bit           e_rel;
      if (chk_en) begin
        e_op = NOP; e_bus = '0; e_rel = 1;
        if (m_act) begin
          if (m_t == 0) begin e_op = WR0; e_bus = m_a; e_rel = 0; end
          else if (m_t == 1) begin e_op = WR1; e_bus = m_b; e_rel = 0; end
          else if (m_t == 2 + TA) begin e_op = m_op; e_bus = alu_f(m_op, m_a, m_b); e_rel = 0; end
        end
        chk($sformatf("L%0d op", g), 32'(op_o[g]), 32'(e_op));
        chk_bus($sformatf("L%0d bus", g), bus === ZZ, bus, e_rel, e_bus);
        chk($sformatf("L%0d req_ready", g), 32'(req_ready[g]),
            32'(!m_act && (!m_pend || resp_ready[g])));
        chk($sformatf("L%0d resp_valid", g), 32'(resp_valid[g]), 32'(m_pend));
        chk($sformatf("L%0d resp_data", g), 32'(resp_data[g]), 32'(m_res));
        chk($sformatf("L%0d busy", g), 32'(busy[g]), 32'(m_act || m_pend));
        chk($sformatf("L%0d txn_count", g), 32'(txn[g]), 32'(m_cnt));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Returns one edge after the accept, i.e. with the DUT in LOAD_A.
  task automatic send(int l, logic [2:0] o, logic [W-1:0] a, logic [W-1:0] b);
    bit got = 0;
    req_valid[l] = 1'b1; req_op[l] = o; req_a[l] = a; req_b[l] = b;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clock);
      got = req_ready[l];
      tick();
    end
    if (!got) chk("send timeout", 0, 1);
    req_valid[l] = 1'b0; req_a[l] = W'($urandom); req_b[l] = W'($urandom);
  endtask

  task automatic wait_resp(int l);
    bit seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      tick();
      seen = resp_valid[l];
    end
    if (!seen) chk("resp timeout", 0, 1);
  endtask

  task automatic rand_lane(int l);
    logic [2:0] o;
    for (int n = 0; n < NRAND; n++) begin
      repeat ($urandom_range(0, 3)) tick();
      o = 3'($urandom_range(3, 7));
      send(l, o, W'($urandom), W'($urandom));
    end
    done_l[l] = 1'b1;
  endtask

  initial begin
    for (int l = 0; l < 2; l++) begin
      req_valid[l] = 0; resp_ready[l] = 1; req_op[l] = NOP; req_a[l] = '0; req_b[l] = '0;
      done_l[l] = 0;
    end
    repeat (3) tick();
    reset = 1'b0;
    chk_en = 1'b1;

    chk("reset op", 32'(op_o[1]), 32'(NOP));
    chk_bus("reset bus", lane[1].bus === ZZ, lane[1].bus, 1, '0);
    chk("reset req_ready", 32'(req_ready[1]), 1);
    chk("reset resp_valid", 32'(resp_valid[1]), 0);
    chk("reset txn_count", 32'(txn[1]), 0);
    chk("reset busy", 32'(busy[1]), 0);

    // 1+5 with the response held back, then a back-to-back 10+20.
    resp_ready[1] = 1'b0;
    send(1, ADD, 8'd1, 8'd5);
    chk("add op0", 32'(op_o[1]), 32'(WR0));
    chk_bus("add bus0", lane[1].bus === ZZ, lane[1].bus, 0, 8'd1);
    tick();
    chk("add op1", 32'(op_o[1]), 32'(WR1));
    chk_bus("add bus1", lane[1].bus === ZZ, lane[1].bus, 0, 8'd5);
    tick();
    chk("add op2", 32'(op_o[1]), 32'(NOP));
    chk_bus("add bus2", lane[1].bus === ZZ, lane[1].bus, 1, '0);
    tick();
    chk("add op3", 32'(op_o[1]), 32'(ADD));
    chk("add early resp", 32'(resp_valid[1]), 0);
    tick();
    chk("add resp_valid", 32'(resp_valid[1]), 1);
    chk("add resp_data", 32'(resp_data[1]), 6);
    chk("add txn_count", 32'(txn[1]), 1);
    req_valid[1] = 1'b1; req_op[1] = ADD; req_a[1] = 8'd10; req_b[1] = 8'd20;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp resp_data", 32'(resp_data[1]), 6);
      chk("bp req_ready", 32'(req_ready[1]), 0);
      chk("bp busy", 32'(busy[1]), 1);
    end
    resp_ready[1] = 1'b1;
    tick();
    req_valid[1] = 1'b0;
    chk("b2b op", 32'(op_o[1]), 32'(WR0));
    chk_bus("b2b bus", lane[1].bus === ZZ, lane[1].bus, 0, 8'd10);
    chk("b2b resp_valid", 32'(resp_valid[1]), 0);
    wait_resp(1);
    chk("b2b resp_data", 32'(resp_data[1]), 30);
    chk("b2b txn_count", 32'(txn[1]), 2);

    send(1, ADD, 8'd200, 8'd100);
    wait_resp(1);
    chk("ovf resp_data", 32'(resp_data[1]), 44);
    chk("ovf txn_count", 32'(txn[1]), 3);

    // TURNAROUND=0 instance: release and compute op share an edge.
    send(0, ADD, 8'd3, 8'd4);
    tick();
    chk("ta0 op1", 32'(op_o[0]), 32'(WR1));
    chk_bus("ta0 bus1", lane[0].bus === ZZ, lane[0].bus, 0, 8'd4);
    tick();
    chk("ta0 op2", 32'(op_o[0]), 32'(ADD));
    chk_bus("ta0 bus2", lane[0].bus === ZZ, lane[0].bus, 0, 8'd7);
    chk("ta0 early resp", 32'(resp_valid[0]), 0);
    tick();
    chk("ta0 resp_valid", 32'(resp_valid[0]), 1);
    chk("ta0 resp_data", 32'(resp_data[0]), 7);

    fork
      rand_lane(0);
      rand_lane(1);
      begin
        for (int c = 0; c < 20000 && !(done_l[0] && done_l[1]); c++) begin
          tick();
          resp_ready[0] = ($urandom_range(0, 3) != 0);
          resp_ready[1] = ($urandom_range(0, 3) != 0);
        end
        resp_ready[0] = 1'b1;
        resp_ready[1] = 1'b1;
      end
    join
    repeat (10) tick();
    chk("rand txn_count L0", 32'(txn[0]), 32'(1 + NRAND));
    chk("rand txn_count L1", 32'(txn[1]), 32'(3 + NRAND));

    // Reset lands mid-LOAD_B.
    send(1, SUB, 8'd9, 8'd3);
    tick();
    chk("rst pre op", 32'(op_o[1]), 32'(WR1));
    #2 reset = 1'b1;
    #1;
    chk_bus("rst bus", lane[1].bus === ZZ, lane[1].bus, 1, '0);
    chk("rst op", 32'(op_o[1]), 32'(NOP));
    chk("rst resp_valid", 32'(resp_valid[1]), 0);
    chk("rst txn_count", 32'(txn[1]), 0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("post-rst resp_valid", 32'(resp_valid[1]), 0);
      chk("post-rst txn_count", 32'(txn[1]), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_bus_master.md
Name: alu_bus_master

Overview:
- Initiator side of the shared-bus ALU protocol: takes an (op, a, b) request over a valid/ready handshake and sequences the ALU through its load and execute ops.
  - Drives `op` and the 8-bit tristate bus to load R0, then R1.
  - Releases the bus for the compute op and samples the ALU's driven result.
- Returns the result over a second valid/ready handshake.
- Sits between the cuca1 control path and the `alu` instance, replacing hand-driven `op`/bus sequencing.

Parameters:
- WIDTH, 8, bus/operand/result width.
- TURNAROUND, 1, idle cycles (op=ALU_NOP, bus released) between the R1 load and the compute op; range 0..3.

Ports:
- clock  input  1  system clock, all state on posedge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  request accepted when req_valid&&req_ready at posedge.
- req_op  input  alu_op_t  compute op issued in EXEC (e.g. ALU_ADD).
- req_a  input  WIDTH  operand loaded into R0.
- req_b  input  WIDTH  operand loaded into R1.
- resp_valid  output  1  result available.
- resp_ready  input  1  result consumed when resp_valid&&resp_ready at posedge.
- resp_data  output  WIDTH  sampled ALU result.
- op  output  alu_op_t  op presented to the ALU.
- bus  inout  WIDTH  shared tristate bus; driven only in LOAD_A/LOAD_B, else 'z.
- busy  output  1  high in any state other than IDLE.
- txn_count  output  16  completed-transaction counter.

Behaviour:
- Clock and reset are fixed: one clock (`clock`); `reset` is asynchronous and active-high.
- Reset values:
  - State=IDLE, op=ALU_NOP, bus released ('z), req_ready=1, resp_valid=0.
  - resp_data=0, busy=0, txn_count=0.
- All outputs are registered, including the bus drive-enable and drive data. No combinational path from req_* to bus or op.
- States: IDLE, LOAD_A, LOAD_B, TURN, EXEC, DONE.
  - IDLE:
    - req_ready=1.
    - On accept, latch req_op/req_a/req_b and go to LOAD_A.
  - LOAD_A:
    - op=ALU_WRITE_R0, bus driven with a, for exactly 1 cycle.
    - Go to LOAD_B.
  - LOAD_B:
    - op=ALU_WRITE_R1, bus driven with b, for 1 cycle.
    - Go to TURN if TURNAROUND>0, else EXEC.
  - TURN:
    - op=ALU_NOP, bus released.
    - Stays TURNAROUND cycles (down-counter), then EXEC.
  - EXEC:
    - op=latched req_op, bus released, for 1 cycle.
    - At the closing posedge, resp_data<=bus, resp_valid<=1, txn_count<=txn_count+1; go to DONE.
  - DONE:
    - op=ALU_NOP, resp_valid=1, resp_data held stable until the handshake.
    - On resp handshake with no new request: resp_valid<=0, go to IDLE.
- Back-to-back: in DONE, req_ready = resp_ready.
  - If both handshakes fire in the same cycle, latch the new request and go directly to LOAD_A; resp_valid drops to 0 at that edge.
- req_ready=0 in LOAD_A, LOAD_B, TURN and EXEC. Requests presented then are held by the source, not dropped.
- Latency: from the accept edge to resp_valid is 3+TURNAROUND cycles (4 at default).
- The bus is never driven in the same cycle the ALU is commanded to output. With TURNAROUND=0, the release and the compute op change on the same edge.
- txn_count wraps 0xFFFF→0x0000.
- resp_data is the raw bus value; WIDTH-bit wrap is the ALU's responsibility (e.g. 200+100 → 44).
- Reset mid-transaction (any state): immediate return to IDLE with reset values.
  - Bus released asynchronously; any pending response is discarded.
  - txn_count is cleared.

Test Plan:
- Reset then idle: after reset, op=ALU_NOP, bus==='z, req_ready=1, resp_valid=0, txn_count=0.
- Single add with `alu` attached: req(ALU_ADD, 1, 5), resp_ready=1 → op sequence WRITE_R0, WRITE_R1, NOP, ADD; bus=1 then 5 then 'z; resp_valid after 4 cycles with resp_data=6; txn_count=1.
- Overflow: req(ALU_ADD, 200, 100) → resp_data=44.
- Backpressure then back-to-back:
  - Hold resp_ready=0 for 5 cycles after resp_valid → resp_data stays 6, req_ready=0, busy=1.
  - Then assert resp_ready with req(ALU_ADD, 10, 20) pending → both fire on one edge, next cycle op=ALU_WRITE_R0, bus=10.
  - Final resp_data=30, txn_count=2.
- Reset mid-op: assert reset during LOAD_B → bus==='z and op=ALU_NOP before the next clock edge; resp_valid=0; no result appears after release.
- TURNAROUND=0 build: req(ALU_ADD, 3, 4) → resp_valid 3 cycles after accept, resp_data=7, and bus never multiply-driven (no X on bus at any sample).
